// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry saturating counters, same-cycle fetch lookup and one EX update per cycle.
// Optional gshare indexing is compiled in when the macro BTP_GSHARE_EN is defined.
module branch_target_predictor #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 6,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [IDX_W-1:0] pred_index,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_mispredict,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispredicts
);

  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'((1 << CNT_W) - 1);

  logic [ENTRIES-1:0] valid_vec;
  logic [TAG_W-1:0]   tag_vec    [ENTRIES];
  logic [31:0]        target_vec [ENTRIES];
  logic [CNT_W-1:0]   cnt_vec    [ENTRIES];

  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [TAG_W-1:0] upd_tag;

  assign pc_idx     = lookup_pc[IDX_W+1:2];
  assign lookup_tag = lookup_pc[IDX_W+2 +: TAG_W];
  assign upd_tag    = upd_pc[IDX_W+2 +: TAG_W];

`ifdef BTP_GSHARE_EN
  // History advances only on resolved branches, so it never needs repair after a flush.
  logic [GHR_W-1:0] ghr_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_reg <= '0;
    end else if (upd_valid) begin
      ghr_reg <= GHR_W'({ghr_reg, upd_taken});
    end
  end
  assign lookup_idx = pc_idx ^ IDX_W'(ghr_reg);
`else
  assign lookup_idx = pc_idx;
`endif

  // Fetch-side lookup: reads current state, so a same-cycle update is seen one cycle later.
  assign pred_index  = lookup_idx;
  assign pred_hit    = valid_vec[lookup_idx] && (tag_vec[lookup_idx] == lookup_tag);
  assign pred_taken  = pred_hit && cnt_vec[lookup_idx][CNT_W-1];
  assign pred_target = pred_taken ? target_vec[lookup_idx] : (lookup_pc + 32'd4);

  logic             upd_hit;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_next;
  logic             alloc;
  logic             write_cnt;
  logic             write_target;

  assign upd_hit = valid_vec[upd_index] && (tag_vec[upd_index] == upd_tag);
  assign cnt_cur = cnt_vec[upd_index];

  always_comb begin
    cnt_next     = cnt_cur;
    alloc        = 1'b0;
    write_cnt    = 1'b0;
    write_target = 1'b0;
    if (upd_valid) begin
      if (upd_hit) begin
        write_cnt = 1'b1;
        if (upd_taken) begin
          write_target = 1'b1;
          if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + CNT_W'(1);
        end else if (cnt_cur != '0) begin
          cnt_next = cnt_cur - CNT_W'(1);
        end
      end else if (upd_taken) begin
        // Taken miss replaces whatever aliased into this slot.
        alloc        = 1'b1;
        write_cnt    = 1'b1;
        write_target = 1'b1;
        cnt_next     = CNT_WEAK_T;
      end
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic             sel;
    logic             valid_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [31:0]      target_reg;

    assign sel = (upd_index == IDX_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        cnt_reg   <= CNT_WEAK_NT;
      end else if (sel) begin
        if (alloc)     valid_reg <= 1'b1;
        if (write_cnt) cnt_reg   <= cnt_next;
      end
    end

    // Tag and target are meaningless while valid is clear, so they carry no reset.
    always_ff @(posedge clk) begin
      if (sel && alloc)        tag_reg    <= upd_tag;
      if (sel && write_target) target_reg <= upd_target;
    end

    assign valid_vec[gi]  = valid_reg;
    assign cnt_vec[gi]    = cnt_reg;
    assign tag_vec[gi]    = tag_reg;
    assign target_vec[gi] = target_reg;
  end

  logic [31:0] perf_branches_reg;
  logic [31:0] perf_mispredicts_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_reg    <= '0;
      perf_mispredicts_reg <= '0;
    end else if (upd_valid) begin
      if (perf_branches_reg != '1) perf_branches_reg <= perf_branches_reg + 32'd1;
      if (upd_mispredict && (perf_mispredicts_reg != '1))
        perf_mispredicts_reg <= perf_mispredicts_reg + 32'd1;
    end
  end

  assign perf_branches    = perf_branches_reg;
  assign perf_mispredicts = perf_mispredicts_reg;

  logic unused_bits;
  assign unused_bits = ^{lookup_pc, upd_pc, (GHR_W <= IDX_W)};

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: vector table for lookup/update, hand sequences for reset and perf counters.
module tb_branch_target_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [5:0]  pred_index;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [5:0]  upd_index;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  int n_cmp;
  int n_fail;

  branch_target_predictor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lookup_pc        (lookup_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .pred_index       (pred_index),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_index        (upd_index),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lk;
    logic        uv;
    logic [31:0] upc;
    logic [5:0]  uidx;
    logic        ut;
    logic [31:0] utgt;
    logic        um;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
    logic [5:0]  eidx;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic [31:0] lk, logic uv, logic [31:0] upc, logic [5:0] uidx,
                              logic ut, logic [31:0] utgt, logic um,
                              logic eh, logic et, logic [31:0] etgt, logic [5:0] eidx);
    vec_t v;
    v.lk = lk; v.uv = uv; v.upc = upc; v.uidx = uidx; v.ut = ut; v.utgt = utgt; v.um = um;
    v.eh = eh; v.et = et; v.etgt = etgt; v.eidx = eidx;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic [5:0] idx,
                         input logic t, input logic [31:0] tgt, input logic m);
    upd_valid = v; upd_pc = pc; upd_index = idx; upd_taken = t; upd_target = tgt; upd_mispredict = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lookup(input string tag, input logic [31:0] pc, input logic eh,
                              input logic et, input logic [31:0] etgt, input logic [5:0] eidx);
    lookup_pc = pc;
    #1;
    $display("%s lk=%h hit=%0d taken=%0d target=%h index=%0d", tag, pc, pred_hit, pred_taken,
             pred_target, pred_index);
    check({tag, " hit"}, 32'(pred_hit), 32'(eh));
    check({tag, " taken"}, 32'(pred_taken), 32'(et));
    check({tag, " target"}, pred_target, etgt);
    check({tag, " index"}, 32'(pred_index), 32'(eidx));
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    lookup_pc = 32'h100;
    set_upd(1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0);
    #12 rst_n = 1'b1;
    tick();

`ifdef BTP_GSHARE_EN
    set_upd(1'b1, 32'h10, 6'd4, 1'b1, 32'h20, 1'b0);
    tick();
    tick();
    set_upd(1'b1, 32'h100, 6'd3, 1'b1, 32'h500, 1'b0);
    check_lookup("gshare_pre", 32'h100, 1'b0, 1'b0, 32'h104, 6'd3);
    tick();
    set_upd(1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0);
    // History is now 6'b000111; pc index 4 XOR 7 lands on entry 3 again.
    check_lookup("gshare_post", 32'h110, 1'b1, 1'b1, 32'h500, 6'd3);
`else
    check("reset perf_branches", perf_branches, 32'd0);
    check("reset perf_mispredicts", perf_mispredicts, 32'd0);

    vecs[0]  = mk(32'h100,      1, 32'h100, 6'd0,  1, 32'h80,  1, 0, 0, 32'h104, 6'd0);
    vecs[1]  = mk(32'h100,      1, 32'h100, 6'd0,  1, 32'h80,  0, 1, 1, 32'h80,  6'd0);
    vecs[2]  = mk(32'h100,      1, 32'h100, 6'd0,  1, 32'h80,  0, 1, 1, 32'h80,  6'd0);
    vecs[3]  = mk(32'h100,      1, 32'h100, 6'd0,  0, 32'h0,   1, 1, 1, 32'h80,  6'd0);
    vecs[4]  = mk(32'h100,      1, 32'h100, 6'd0,  0, 32'h0,   1, 1, 1, 32'h80,  6'd0);
    vecs[5]  = mk(32'h100,      1, 32'h200, 6'd0,  0, 32'h0,   0, 1, 0, 32'h104, 6'd0);
    vecs[6]  = mk(32'h200,      0, 32'h200, 6'd0,  1, 32'h999, 1, 0, 0, 32'h204, 6'd0);
    vecs[7]  = mk(32'h100,      1, 32'h200, 6'd0,  1, 32'h300, 1, 1, 0, 32'h104, 6'd0);
    vecs[8]  = mk(32'h200,      0, 32'h0,   6'd0,  0, 32'h0,   0, 1, 1, 32'h300, 6'd0);
    vecs[9]  = mk(32'h100,      1, 32'h1FC, 6'd63, 1, 32'h40,  0, 0, 0, 32'h104, 6'd0);
    vecs[10] = mk(32'h1FC,      1, 32'h1FC, 6'd63, 1, 32'h44,  0, 1, 1, 32'h40,  6'd63);
    vecs[11] = mk(32'h1FC,      0, 32'h0,   6'd0,  0, 32'h0,   0, 1, 1, 32'h44,  6'd63);
    vecs[12] = mk(32'hFFFF_FFFC, 0, 32'h0,  6'd0,  0, 32'h0,   0, 0, 0, 32'h0,   6'd63);

    // Each vector checks the lookup before its own update lands, then clocks the update in.
    for (int i = 0; i < 13; i++) begin
      set_upd(vecs[i].uv, vecs[i].upc, vecs[i].uidx, vecs[i].ut, vecs[i].utgt, vecs[i].um);
      check_lookup($sformatf("vec%0d", i), vecs[i].lk, vecs[i].eh, vecs[i].et, vecs[i].etgt,
                   vecs[i].eidx);
      tick();
    end
    set_upd(1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0);
    check("table perf_branches", perf_branches, 32'd9);
    check("table perf_mispredicts", perf_mispredicts, 32'd4);

    // Async reset between edges clears the table and counters.
    rst_n = 1'b0;
    #1;
    check("rst1 perf_branches", perf_branches, 32'd0);
    check("rst1 perf_mispredicts", perf_mispredicts, 32'd0);
    check_lookup("rst1", 32'h200, 1'b0, 1'b0, 32'h204, 6'd0);
    rst_n = 1'b1;
    tick();

    // Counter floors at zero: 2 -> 1 -> 0 -> 0, then two taken updates bring it back to 2.
    set_upd(1'b1, 32'h100, 6'd0, 1'b1, 32'h80, 1'b1); tick();
    set_upd(1'b1, 32'h100, 6'd0, 1'b0, 32'h0,  1'b1); tick();
    set_upd(1'b1, 32'h100, 6'd0, 1'b0, 32'h0,  1'b0); tick();
    set_upd(1'b1, 32'h100, 6'd0, 1'b0, 32'h0,  1'b0); tick();
    set_upd(1'b1, 32'h100, 6'd0, 1'b1, 32'h88, 1'b0); tick();
    set_upd(1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0);
    check_lookup("floor1", 32'h100, 1'b1, 1'b0, 32'h104, 6'd0);
    set_upd(1'b1, 32'h100, 6'd0, 1'b1, 32'h8C, 1'b0); tick();
    set_upd(1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0);
    check_lookup("floor2", 32'h100, 1'b1, 1'b1, 32'h8C, 6'd0);

    for (int i = 0; i < 4; i++) begin
      set_upd(1'b1, 32'h400, 6'd0, 1'b0, 32'h0, (i == 2));
      tick();
    end
    set_upd(1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0);
    check_lookup("nt_miss", 32'h400, 1'b0, 1'b0, 32'h404, 6'd0);
    $display("perf branches=%0d mispredicts=%0d", perf_branches, perf_mispredicts);
    check("perf_branches 10", perf_branches, 32'd10);
    check("perf_mispredicts 3", perf_mispredicts, 32'd3);

    set_upd(1'b1, 32'h100, 6'd0, 1'b1, 32'h80, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst2 perf_branches", perf_branches, 32'd0);
    check("rst2 perf_mispredicts", perf_mispredicts, 32'd0);
    rst_n = 1'b1;
    set_upd(1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0);
    tick();
    check_lookup("rst2", 32'h100, 1'b0, 1'b0, 32'h104, 6'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
